// File: rtl/adder_tree_sched.sv
// Round-robin scheduler feeding one shared pipelined 256x4 adder tree.
// Optional statistics counters: define SCHED_STATS_EN.
module adder_tree_sched #(
  parameter int NREQ    = 4,
  parameter int LAT     = 8,
  parameter int MAX_OUT = 4,
  parameter int IDW     = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*1024-1:0]   req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [1023:0]          tree_data,
  input  logic [11:0]            tree_sum,
  output logic [NREQ-1:0]        resp_valid,
  output logic [11:0]            resp_sum,
  output logic [IDW-1:0]         resp_id,
  input  logic                   flush_req,
  output logic                   flush_done,
`ifdef SCHED_STATS_EN
  input  logic                   stats_clr,
  output logic [NREQ*16-1:0]     grant_cnt,
  output logic [15:0]            stall_cnt,
`endif
  output logic                   busy
);

  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic {RUN, DRAIN} state_e;

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
  } tag_t;

  state_e                   state_q, state_d;
  logic                     sent_q, sent_d;
  logic                     fdone_d;
  logic [IDW-1:0]           ptr_q, ptr_d;
  logic [NREQ-1:0][CW-1:0]  out_q, out_d;
  tag_t                     tag_q [LAT+1];
  logic [1023:0]            tree_data_q, tree_data_d;
  logic [NREQ-1:0]          resp_valid_q, rv_d;
  logic [11:0]              resp_sum_q;
  logic [IDW-1:0]           resp_id_q;
  logic                     flush_done_q;
  logic [NREQ-1:0]          elig, gnt;
  logic [IDW-1:0]           win;
  logic                     found;
  tag_t                     tag_exit;

  assign tag_exit   = tag_q[LAT];
  assign req_ready  = gnt;
  assign tree_data  = tree_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_sum   = resp_sum_q;
  assign resp_id    = resp_id_q;
  assign flush_done = flush_done_q;

  always_comb begin
    rv_d = '0;
    for (int j = 0; j < NREQ; j++) begin
      rv_d[j] = tag_exit.v && (tag_exit.id == IDW'(j));
    end
  end

  // A credit returning this cycle may be reused by an accept on the same edge
  always_comb begin
    elig = '0;
    for (int j = 0; j < NREQ; j++) begin
      elig[j] = reset_n && req_valid[j] && (state_q == RUN) &&
                ((out_q[j] - CW'(rv_d[j])) < CW'(MAX_OUT));
    end
  end

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && elig[j] && (j == (int'(ptr_q) + k) % NREQ)) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          win    = IDW'(j);
        end
      end
    end
    ptr_d = found ? IDW'((int'(win) + 1) % NREQ) : ptr_q;
  end

  always_comb begin
    tree_data_d = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt[j]) tree_data_d = req_data[1024*j +: 1024];
    end
  end

  always_comb begin
    for (int j = 0; j < NREQ; j++) begin
      out_d[j] = out_q[j] + CW'(gnt[j]) - CW'(rv_d[j]);
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      busy = busy | tag_q[k].v;
    end
  end

  always_comb begin
    state_d = state_q;
    sent_d  = sent_q;
    fdone_d = 1'b0;
    unique case (state_q)
      RUN: begin
        sent_d = 1'b0;
        if (flush_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (!busy) begin
          if (!sent_q) begin
            fdone_d = 1'b1;
            sent_d  = 1'b1;
          end
          if (!flush_req) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= RUN;
      sent_q       <= 1'b0;
      ptr_q        <= '0;
      out_q        <= '0;
      tree_data_q  <= '0;
      resp_valid_q <= '0;
      resp_sum_q   <= '0;
      resp_id_q    <= '0;
      flush_done_q <= 1'b0;
      for (int k = 0; k <= LAT; k++) tag_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      sent_q       <= sent_d;
      ptr_q        <= ptr_d;
      out_q        <= out_d;
      tree_data_q  <= tree_data_d;
      flush_done_q <= fdone_d;
      resp_valid_q <= rv_d;
      tag_q[0]     <= '{v: found, id: win};
      for (int k = 1; k <= LAT; k++) tag_q[k] <= tag_q[k-1];
      if (tag_exit.v) begin
        resp_sum_q <= tree_sum;
        resp_id_q  <= tag_exit.id;
      end
    end
  end

`ifdef SCHED_STATS_EN
  logic [NREQ-1:0][15:0] grant_q;
  logic [15:0]           stall_q;

  assign grant_cnt = grant_q;
  assign stall_cnt = stall_q;

  always_ff @(posedge clk) begin
    if (!reset_n || stats_clr) begin
      grant_q <= '0;
      stall_q <= '0;
    end else begin
      for (int j = 0; j < NREQ; j++) begin
        if (gnt[j] && grant_q[j] != 16'hFFFF) grant_q[j] <= grant_q[j] + 16'd1;
      end
      if (state_q == RUN && |req_valid && !found && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed bench for adder_tree_sched with a behavioural LAT-stage tree.
// Stats checks compile in when SCHED_STATS_EN is defined.
module tb_adder_tree_sched;

  localparam int NREQ    = 4;
  localparam int LAT     = 8;
  localparam int MAX_OUT = 4;
  localparam int IDW     = 3;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*1024-1:0]  req_data;
  logic [NREQ-1:0]       req_ready;
  logic [1023:0]         tree_data;
  logic [11:0]           tree_sum;
  logic [NREQ-1:0]       resp_valid;
  logic [11:0]           resp_sum;
  logic [IDW-1:0]        resp_id;
  logic                  flush_req;
  logic                  flush_done;
  logic                  busy;
`ifdef SCHED_STATS_EN
  logic                  stats_clr;
  logic [NREQ*16-1:0]    grant_cnt;
  logic [15:0]           stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  adder_tree_sched #(
    .NREQ(NREQ), .LAT(LAT), .MAX_OUT(MAX_OUT), .IDW(IDW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tree_data(tree_data),
    .tree_sum(tree_sum),
    .resp_valid(resp_valid),
    .resp_sum(resp_sum),
    .resp_id(resp_id),
    .flush_req(flush_req),
    .flush_done(flush_done),
`ifdef SCHED_STATS_EN
    .stats_clr(stats_clr),
    .grant_cnt(grant_cnt),
    .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  function automatic logic [11:0] nsum(input logic [1023:0] d);
    int s = 0;
    for (int i = 0; i < 256; i++) s += int'(d[4*i +: 4]);
    return 12'(s);
  endfunction

  function automatic logic [1023:0] fill(input logic [3:0] n);
    logic [1023:0] r;
    for (int i = 0; i < 256; i++) r[4*i +: 4] = n;
    return r;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int k);
    return NREQ'(1) << k;
  endfunction

  // Free-running tree: sum of tree_data appears LAT cycles later
  logic [11:0] tpipe [LAT];
  initial for (int k = 0; k < LAT; k++) tpipe[k] = '0;
  always @(posedge clk) begin
    tpipe[0] <= nsum(tree_data);
    for (int k = 1; k < LAT; k++) tpipe[k] <= tpipe[k-1];
  end
  assign tree_sum = tpipe[LAT-1];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int own [5] = '{0, 1, 0, 1, 0};
  int pulses;

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    flush_req = 1'b0;
`ifdef SCHED_STATS_EN
    stats_clr = 1'b0;
`endif
    tick();
    tick();
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_tree", 32'(|tree_data), 0);
    chk("rst_rvalid", 32'(resp_valid), 0);
    chk("rst_rsum", 32'(resp_sum), 0);
    chk("rst_rid", 32'(resp_id), 0);
    chk("rst_fdone", 32'(flush_done), 0);
    chk("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;

    // single request, all nibbles F
    req_data[0 +: 1024] = fill(4'hF);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    chk("single_busy", 32'(busy), 1);
    repeat (8) begin
      tick();
      chk("single_early", 32'(resp_valid), 0);
    end
    tick();
    chk("single_rvalid", 32'(resp_valid), 32'b0001);
    chk("single_sum", 32'(resp_sum), 3840);
    chk("single_id", 32'(resp_id), 0);
    chk("single_busy_lo", 32'(busy), 0);
    tick();
    chk("single_rvalid_lo", 32'(resp_valid), 0);
    chk("single_sum_hold", 32'(resp_sum), 3840);

    // fairness: 40 accepts rotating 0..3
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < NREQ; i++) req_data[1024*i +: 1024] = fill(4'(i + 1));
    req_valid = 4'hF;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (c < 40) chk("fair_ready", 32'(req_ready), 32'(oh(c % 4)));
      tick();
      if (c == 39) req_valid = '0;
      if (c >= 9 && c - 9 < 40) begin
        chk("fair_rvalid", 32'(resp_valid), 32'(oh((c - 9) % 4)));
        chk("fair_sum", 32'(resp_sum), 256 * ((c - 9) % 4 + 1));
        chk("fair_id", 32'(resp_id), (c - 9) % 4);
      end else begin
        chk("fair_idle", 32'(resp_valid), 0);
      end
    end

`ifdef SCHED_STATS_EN
    for (int i = 0; i < NREQ; i++)
      chk("stat_grant", 32'(grant_cnt[16*i +: 16]), 10);
    chk("stat_stall", 32'(stall_cnt), 0);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    for (int i = 0; i < NREQ; i++)
      chk("stat_grant_clr", 32'(grant_cnt[16*i +: 16]), 0);
    chk("stat_stall_clr", 32'(stall_cnt), 0);
`endif

    // credit limit: requester 2 streams alone, 4 accepts per 9 cycles
    req_data[2048 +: 1024] = fill(4'h2);
    req_valid = 4'b0100;
    for (int c = 0; c < 27; c++) begin
      #1;
      chk("credit_ready", 32'(req_ready), ((c % 9) < 4) ? 32'b0100 : 0);
      tick();
      if (c == 9) begin
        chk("credit_rvalid", 32'(resp_valid), 32'b0100);
        chk("credit_sum", 32'(resp_sum), 512);
      end
    end
    req_valid = '0;
    repeat (12) tick();

    // flush with 5 in flight
    req_data[0 +: 1024]    = fill(4'h3);
    req_data[1024 +: 1024] = fill(4'h4);
    req_valid = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("flush_issue", 32'(req_ready), 32'(oh(own[c])));
      if (c == 4) flush_req = 1'b1;
      tick();
    end
    pulses = 0;
    for (int c = 5; c < 16; c++) begin
      #1;
      chk("flush_ready", 32'(req_ready), 0);
      tick();
      if (flush_done) pulses++;
      if (c >= 9 && c <= 13) begin
        chk("flush_rvalid", 32'(resp_valid), 32'(oh(own[c - 9])));
        chk("flush_sum", 32'(resp_sum), (own[c - 9] == 0) ? 768 : 1024);
      end else begin
        chk("flush_idle", 32'(resp_valid), 0);
      end
      if (c == 12) chk("flush_busy_hi", 32'(busy), 1);
      if (c == 13) chk("flush_busy_lo", 32'(busy), 0);
      chk("flush_done", 32'(flush_done), (c == 14) ? 1 : 0);
    end
    flush_req = 1'b0;
    #1;
    chk("flush_hold", 32'(req_ready), 0);
    tick();
    if (flush_done) pulses++;
    #1;
    chk("flush_resume", 32'(req_ready), 32'b0010);
    chk("flush_pulses", 32'(pulses), 1);
    req_valid = '0;

    // reset with 6 tags in flight
    req_valid = 4'hF;
    repeat (6) tick();
    chk("mid_busy", 32'(busy), 1);
    req_valid = '0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rsum", 32'(resp_sum), 0);
    chk("mid_rst_tree", 32'(|tree_data), 0);
    repeat (9) begin
      tick();
      chk("mid_no_resp", 32'(resp_valid), 0);
    end
    req_data[1024 +: 1024] = fill(4'h5);
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("mid_credit", 32'(req_ready), (c < 4) ? 32'b0010 : 0);
      tick();
    end
    req_valid = '0;
    for (int c = 5; c < 14; c++) begin
      tick();
      if (c >= 9 && c <= 12) begin
        chk("mid_rvalid", 32'(resp_valid), 32'b0010);
        chk("mid_sum", 32'(resp_sum), 1280);
        chk("mid_id", 32'(resp_id), 1);
      end else begin
        chk("mid_idle", 32'(resp_valid), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
